// File: rtl/stack_pkg.sv
// Shared definitions for the stack engine: operation encoding and the
// depth-counter width helper.
package stack_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_ADD  = 3'd5,
        OP_SUB  = 3'd6,
        OP_AND  = 3'd7
    } op_t;

    function automatic int depth_w(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand ALU for the stack engine: a is NOS, b is TOS.
module stack_alu
    import stack_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/stack_engine.sv
// Operand stack with registered TOS/NOS, a depth-addressed backing array and
// an integrated ALU. Optional sticky error mode: define STACK_ERR_STICKY_EN.
module stack_engine
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_valid,
    input  logic [OP_W-1:0]             op,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        err_clr,
    output logic                        op_ready,
    output logic [WIDTH-1:0]            tos,
    output logic [WIDTH-1:0]            nos,
    output logic [depth_w(DEPTH)-1:0]   depth,
    output logic                        empty,
    output logic                        full,
    output logic                        zero,
    output logic                        err_ovf,
    output logic                        err_unf
);

    localparam int              DW      = depth_w(DEPTH);
    localparam int              MEM_N   = 1 << DW;
    localparam logic [DW-1:0]   DEPTH_L = DW'(DEPTH);

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             zero_q, zero_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;

    // Stack position k (0 = bottom) lives at mem[k]; only k <= depth-3 is live
    logic [WIDTH-1:0] mem [MEM_N];
    logic             mem_we;
    logic [DW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_raddr;
    logic [WIDTH-1:0] nos_fill;

    op_t              op_e;
    logic             accept;
    logic             is_full, has1, has2, has3;
    logic             ovf_evt, unf_evt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    assign op_e = op_t'(op);

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (nos_q),
        .b      (tos_q),
        .op     (op_e),
        .result (alu_result),
        .zero   (alu_zero)
    );

`ifdef STACK_ERR_STICKY_EN
    assign op_ready = !(err_ovf_q || err_unf_q);
    assign accept   = op_valid && op_ready && !err_clr;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign op_ready       = 1'b1;
    assign accept         = op_valid;
`endif

    assign is_full   = (depth_q == DEPTH_L);
    assign has1      = (depth_q != '0);
    assign has2      = (depth_q >= DW'(2));
    assign has3      = (depth_q >= DW'(3));
    assign mem_waddr = depth_q - DW'(2);
    assign mem_raddr = depth_q - DW'(3);
    assign nos_fill  = has3 ? mem[mem_raddr] : '0;

    always_comb begin
        tos_d   = tos_q;
        nos_d   = nos_q;
        depth_d = depth_q;
        zero_d  = zero_q;
        mem_we  = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;

        if (accept) begin
            case (op_e)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_evt = 1'b1;
                    end else begin
                        tos_d   = push_data;
                        nos_d   = tos_q;
                        depth_d = depth_q + DW'(1);
                        mem_we  = has2;
                    end
                end
                OP_DUP: begin
                    if (is_full) begin
                        ovf_evt = 1'b1;
                    end else if (!has1) begin
                        unf_evt = 1'b1;
                    end else begin
                        nos_d   = tos_q;
                        depth_d = depth_q + DW'(1);
                        mem_we  = has2;
                    end
                end
                OP_POP: begin
                    if (!has1) begin
                        unf_evt = 1'b1;
                    end else begin
                        tos_d   = nos_q;
                        nos_d   = nos_fill;
                        depth_d = depth_q - DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has2) begin
                        unf_evt = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                OP_ADD, OP_SUB, OP_AND: begin
                    if (!has2) begin
                        unf_evt = 1'b1;
                    end else begin
                        tos_d   = alu_result;
                        nos_d   = nos_fill;
                        depth_d = depth_q - DW'(1);
                        zero_d  = alu_zero;
                    end
                end
                default: begin
                end
            endcase
        end

`ifdef STACK_ERR_STICKY_EN
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end else begin
            err_ovf_d = err_ovf_q || ovf_evt;
            err_unf_d = err_unf_q || unf_evt;
        end
`else
        err_ovf_d = ovf_evt;
        err_unf_d = unf_evt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q     <= '0;
            nos_q     <= '0;
            depth_q   <= '0;
            zero_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            tos_q     <= tos_d;
            nos_q     <= nos_d;
            depth_q   <= depth_d;
            zero_q    <= zero_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Old NOS spills to the array when a push moves it below position depth-2
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= nos_q;
        end
    end

    assign tos     = tos_q;
    assign nos     = nos_q;
    assign depth   = depth_q;
    assign empty   = (depth_q == '0);
    assign full    = is_full;
    assign zero    = zero_q;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

endmodule

// File: doc/stack_engine.md
# stack_engine

Parametrised operand stack with an integrated two-operand ALU. It is the storage-and-execute core for the next-generation stack-machine datapath, and replaces the fixed push/pop/tos stack strobes with a single encoded-operation interface. Each operation is accepted in one cycle and updates top-of-stack (TOS), next-on-stack (NOS), depth and flags. Overflow and underflow are detected and reported rather than corrupting state.

## Interface
Parameters:
- WIDTH, 8, data word width (≥2)
- DEPTH, 16, maximum number of entries (≥2, any integer, not restricted to powers of two)

Ports:
- clk  in  1  clock; rising edge
- rst_n  in  1  reset; asynchronous, active-low
- op_valid  in  1  operation request
- op  in  3  operation code: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 AND
- push_data  in  WIDTH  operand for PUSH
- err_clr  in  1  clears sticky error; only effective with STACK_ERR_STICKY_EN
- op_ready  out  1  engine accepts an operation this cycle
- tos  out  WIDTH  top entry, registered; 0 when depth = 0
- nos  out  WIDTH  second entry, registered; 0 when depth < 2
- depth  out  $clog2(DEPTH+1)  current entry count
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- zero  out  1  last ALU result == 0
- err_ovf  out  1  overflow error flag
- err_unf  out  1  underflow error flag

## Operation
- Accept: op_valid && op_ready on a rising clk edge. Without the macro, op_ready is constantly 1 after reset.
- PUSH: requires !full; new TOS = push_data, old TOS becomes NOS.
- POP: requires depth ≥ 1; discards TOS.
- DUP: requires depth ≥ 1 and !full; pushes a copy of TOS.
- SWAP: requires depth ≥ 2; exchanges TOS and NOS; depth unchanged.
- ADD / SUB / AND: require depth ≥ 2. Pop both operands; push NOS+TOS, NOS−TOS or NOS&TOS. Net depth −1.
- ALU arithmetic: modulo 2^WIDTH, no carry output. zero is updated only by ALU ops and holds otherwise.
- Illegal ops (precondition fails):
  - No state change.
  - PUSH or DUP on full raises err_ovf.
  - Any other failed precondition raises err_unf.
- NOP, or op_valid low: no change.
- Storage: entries at index ≥ 2 are held in an array addressed by depth. Array contents are never observable beyond depth.

## Timing
- Reset (asynchronous assert, synchronous to clk on release): depth=0, tos=0, nos=0, empty=1, full=0, zero=0, err_ovf=0, err_unf=0, op_ready=1. Array contents are don't-care.
- Latency: every output reflects an accepted op on the first rising edge after acceptance. Back-to-back ops are allowed every cycle.
- tos and nos always equal the true top two entries, or 0 where absent. Entries below NOS are refilled on the same edge as POP or ALU ops.
- Error flags (without macro): single-cycle pulse in the cycle after the illegal op.
- Reset asserted mid-sequence: all state is discarded immediately; no partial op completes.

## Configuration
- STACK_ERR_STICKY_EN defined:
  - err_ovf and err_unf are sticky once set.
  - While either flag is set, op_ready = 0 and ops are ignored.
  - err_clr = 1 clears both flags on the next edge. err_clr has priority over a concurrent illegal op; no op is accepted in the same cycle as err_clr.
- STACK_ERR_STICKY_EN undefined:
  - Flags pulse for one cycle.
  - op_ready stays 1.
  - err_clr is ignored.

## Structure
- Shared package stack_pkg holds:
  - the op_t enum (3-bit, values above);
  - localparam OP_W = 3;
  - a helper function for depth width.
- Sub-module stack_alu: combinational. Inputs: a=NOS, b=TOS and op. Outputs: WIDTH result and zero.
- stack_engine holds the registered TOS/NOS, the depth counter, the array and the flag logic.

## Test plan
- Reset, then PUSH 0x05, PUSH 0x03, ADD → tos=0x08, depth=1, zero=0, nos=0.
- PUSH 0x03, PUSH 0x03, SUB → tos=0x00, zero=1; with WIDTH=8, PUSH 0x00, PUSH 0x01, SUB → tos=0xFF.
- Fill with DEPTH PUSHes (values 1..DEPTH) → full=1. Then issue PUSH 0xAA → err_ovf pulses, tos=DEPTH, depth unchanged. Then pop all → tos/nos follow DEPTH−1, DEPTH−2 …, and empty=1 at the end.
- Empty stack, POP, then ADD with depth=1 → err_unf each time, depth and tos unchanged.
- PUSH 0x11, PUSH 0x22, SWAP, DUP → tos=0x11, nos=0x11, depth=3. Then AND → tos=0x11, nos=0x22.
- With STACK_ERR_STICKY_EN: POP on empty → err_unf stays 1, op_ready=0, and a following PUSH is ignored. Assert err_clr → flags clear, op_ready=1, and the next PUSH 0x7 gives tos=0x7.
